// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32 load/store memory stage.
//   - RISC-V funct3 width/sign codes used by loads and stores
//   - FSM state encoding for the bus transaction sequencer
//   - byte-enable base patterns (shifted by the address offset)
package lsu_pkg;

  localparam int unsigned LSU_XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment and extension (purely combinational).
//   rdata   : raw 32-bit word returned by the data bus
//   addr_lo : byte offset of the access within the word
//   funct3  : RISC-V load width/sign code
//   ld_data : selected byte/half/word, sign- or zero-extended
import lsu_pkg::*;

module lsu_load_align (
  input  logic [LSU_XLEN-1:0] rdata,
  input  logic [1:0]          addr_lo,
  input  logic [2:0]          funct3,
  output logic [LSU_XLEN-1:0] ld_data
);

  logic [LSU_XLEN-1:0] shifted;

  always_comb begin
    // Move the addressed lane down to bit 0; halfwords are aligned so
    // addr_lo[0] is always 0 for them.
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'h000000, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'h0000, shifted[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage of the RV32 pipeline.
// Accepts one load/store from execute, runs a req/gnt/rvalid data-bus
// transaction, and reports exactly one completion/exception pulse.
//   clk, rst                : clock, asynchronous active-high reset
//   ex_*                    : instruction from execute (valid, type, funct3,
//                             address, store data, cancel)
//   flush                   : pipeline flush
//   dbus_req/we/addr/be/wdata : bus request (word-aligned, lane-replicated)
//   dbus_gnt/rvalid/rdata/err : bus handshake and response
//   hold                    : stall upstream and the MEM/WB register
//   ld_data, ld_valid       : load result and completion pulse
//   misalign_exc            : misaligned-address pulse
//   access_fault            : bus error or illegal funct3 pulse
import lsu_pkg::*;

module lsu_mem_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            ex_cancel,
  input  logic            flush,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [3:0]      dbus_be,
  output logic [XLEN-1:0] dbus_wdata,
  input  logic            dbus_gnt,
  input  logic            dbus_rvalid,
  input  logic [XLEN-1:0] dbus_rdata,
  input  logic            dbus_err,
  output logic            hold,
  output logic [XLEN-1:0] ld_data,
  output logic            ld_valid,
  output logic            misalign_exc,
  output logic            access_fault
);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            ill_q, ill_d;
  logic            mis_q, mis_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;

  logic            accept;
  logic            f3_illegal;
  logic            addr_misalign;
  logic [3:0]      be_new;
  logic [XLEN-1:0] wdata_new;
  logic [XLEN-1:0] align_data;
  logic            pulse_en;

  lsu_load_align u_align (
    .rdata   (rdata_q),
    .addr_lo (off_q),
    .funct3  (funct3_q),
    .ld_data (align_data)
  );

  // Decode of the incoming instruction.
  always_comb begin
    accept = ~rst & (state_q == ST_IDLE) & ex_valid & (ex_is_load | ex_is_store)
             & ~ex_cancel & ~flush;

    if (ex_is_load) f3_illegal = (ex_funct3 == 3'b011) | (ex_funct3[2:1] == 2'b11);
    else            f3_illegal = ex_funct3[2] | (ex_funct3[1:0] == 2'b11);

    case (ex_funct3[1:0])
      2'b01:   addr_misalign = ex_addr[0];
      2'b10:   addr_misalign = |ex_addr[1:0];
      default: addr_misalign = 1'b0;
    endcase

    case (ex_funct3[1:0])
      2'b00:   be_new = BE_BYTE << ex_addr[1:0];
      2'b01:   be_new = BE_HALF << {ex_addr[1], 1'b0};
      default: be_new = BE_WORD;
    endcase

    case (ex_funct3[1:0])
      2'b00:   wdata_new = {4{ex_wdata[7:0]}};
      2'b01:   wdata_new = {2{ex_wdata[15:0]}};
      default: wdata_new = ex_wdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ill_d    = ill_q;
    mis_d    = mis_q;
    kill_d   = kill_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d     = ~ex_is_load;
          addr_d   = {ex_addr[XLEN-1:2], 2'b00};
          be_d     = be_new;
          wdata_d  = wdata_new;
          funct3_d = ex_funct3;
          off_d    = ex_addr[1:0];
          err_d    = 1'b0;
          // An illegal funct3 is a fault, never a misalignment.
          ill_d    = f3_illegal;
          mis_d    = addr_misalign & ~f3_illegal;
          state_d  = (f3_illegal | addr_misalign) ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        // A flushed request is still carried to completion; only its
        // result is discarded.
        if (flush)    kill_d  = 1'b1;
        if (dbus_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush) kill_d = 1'b1;
        if (dbus_rvalid) begin
          rdata_d = dbus_rdata;
          err_d   = dbus_err;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        kill_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    dbus_req   = (state_q == ST_REQ);
    dbus_we    = dbus_req & we_q;
    dbus_addr  = dbus_req ? addr_q  : '0;
    dbus_be    = dbus_req ? be_q    : '0;
    dbus_wdata = dbus_req ? wdata_q : '0;

    hold = (state_q == ST_REQ) | (state_q == ST_WAIT) | accept;

    pulse_en     = (state_q == ST_RESP) & ~kill_q & ~flush;
    misalign_exc = pulse_en & mis_q;
    access_fault = pulse_en & ~mis_q & (ill_q | err_q);
    ld_valid     = pulse_en & ~mis_q & ~ill_q & ~err_q;

    ld_data   = ld_valid ? (we_q ? '0 : align_data) : ld_data_q;
    ld_data_d = ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ill_q     <= 1'b0;
      mis_q     <= 1'b0;
      kill_q    <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ill_q     <= ill_d;
      mis_q     <= mis_d;
      kill_q    <= kill_d;
      ld_data_q <= ld_data_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed scenarios plus randomized
// transactions checked against an arithmetic reference model.
module tb_lsu_mem_stage;

  logic        clk, rst;
  logic        ex_valid, ex_is_load, ex_is_store, ex_cancel, flush;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid, dbus_err;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        hold, ld_valid, misalign_exc, access_fault;
  logic [31:0] ld_data;

  int tests_run = 0;
  int tests_failed = 0;

  lsu_mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_cancel(ex_cancel), .flush(flush),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .dbus_err(dbus_err),
    .hold(hold), .ld_data(ld_data), .ld_valid(ld_valid),
    .misalign_exc(misalign_exc), .access_fault(access_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] rd,
                                         input logic [1:0] off);
    int unsigned sh, v;
    sh = 8 * int'(off);
    case (f3)
      3'b000, 3'b100: begin
        v = (rd >> sh) & 32'hFF;
        if (f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = (rd >> sh) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic int unsigned m_size(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned mask;
    mask = ((32'd1 << m_size(f3)) - 1) << (a % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (m_size(f3) == 1) return (w & 32'hFF) * 32'h01010101;
    if (m_size(f3) == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  // 0 = ok, 1 = misaligned, 2 = illegal funct3
  function automatic int m_kind(input logic ld, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    if (ld) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else    legal = (f3 <= 3'd2);
    if (!legal) return 2;
    if ((a % m_size(f3)) != 0) return 1;
    return 0;
  endfunction

  // ---------------- transaction driver / bus slave ----------------
  // gcyc: req cycles up to and including the gnt cycle; rvd: extra WAIT
  // cycles before rvalid; flush_k: cycle index (after accept) with flush.
  task automatic drive_txn(
    input  logic ld, input logic [2:0] f3, input logic [31:0] addr, wdata, rdata,
    input  logic err, input int gcyc, input int rvd, input int flush_k,
    output int hold_n, output int req_n, output logic [31:0] r_addr, r_wdata,
    output logic [3:0] r_be, output logic r_we, output logic stable,
    output int resp_k, output logic [2:0] pulses, output logic [31:0] r_ld,
    output logic extra);
    int phase, wait_n;
    hold_n = 0; req_n = 0; r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0;
    stable = 1'b1; resp_k = -1; pulses = '0; r_ld = '0; extra = 1'b0;
    phase = 0; wait_n = 0;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = !ld; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wdata; ex_cancel = 1'b0; flush = 1'b0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_err = 1'b0;
    #1;
    if (hold) hold_n++;
    if (ld_valid | misalign_exc | access_fault | dbus_req) extra = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_addr = $urandom; ex_wdata = $urandom; ex_funct3 = 3'($urandom);
      flush = (k == flush_k);
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_err = 1'b0; dbus_rdata = $urandom;
      if (phase == 1) begin
        wait_n++;
        if (wait_n > rvd) begin
          dbus_rvalid = 1'b1; dbus_rdata = rdata; dbus_err = err; phase = 2;
        end
      end
      #1;
      if (dbus_req) begin
        req_n++;
        if (req_n == 1) begin
          r_addr = dbus_addr; r_wdata = dbus_wdata; r_be = dbus_be; r_we = dbus_we;
        end else if (dbus_addr !== r_addr || dbus_wdata !== r_wdata ||
                     dbus_be !== r_be || dbus_we !== r_we) begin
          stable = 1'b0;
        end
        if (phase == 0 && req_n >= gcyc) begin dbus_gnt = 1'b1; phase = 1; end
      end
      if (int'(ld_valid) + int'(misalign_exc) + int'(access_fault) > 1) extra = 1'b1;
      if ((ld_valid | misalign_exc | access_fault) && hold) extra = 1'b1;
      pulses = pulses | {ld_valid, misalign_exc, access_fault};
      if (ld_valid) r_ld = ld_data;
      if (!hold) begin resp_k = k; break; end
      hold_n++;
    end
    @(posedge clk); #1;
    flush = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_err = 1'b0;
    #1;
    if (ld_valid | misalign_exc | access_fault | dbus_req | hold) extra = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  int hn, rn, rk;
  logic [31:0] ra, rw, rl;
  logic [3:0] rb;
  logic rwe, st, ex;
  logic [2:0] pl;

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (hold !== 1'b0) begin tests_failed++; $display("FAIL reset_hold: got %b want 0", hold); end
    tests_run++;
    if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, ld_data, ld_valid, misalign_exc, access_fault} !== '0) begin
      tests_failed++; $display("FAIL reset_outputs: req=%b we=%b addr=%h be=%h wd=%h ld=%h v=%b m=%b f=%b want all 0",
        dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, ld_data, ld_valid, misalign_exc, access_fault);
    end
    ex_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_lw_basic();
    drive_txn(1'b1, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0, 1, 0, 0,
              hn, rn, ra, rw, rb, rwe, st, rk, pl, rl, ex);
    tests_run++; if (rb !== 4'hF) begin tests_failed++; $display("FAIL lw_be: got %h want f", rb); end
    tests_run++; if (ra !== 32'h1000) begin tests_failed++; $display("FAIL lw_addr: got %h want 00001000", ra); end
    tests_run++; if (rwe !== 1'b0) begin tests_failed++; $display("FAIL lw_we: got %b want 0", rwe); end
    tests_run++; if (rk != 3) begin tests_failed++; $display("FAIL lw_latency: got %0d want 3", rk); end
    tests_run++; if (hn != 3) begin tests_failed++; $display("FAIL lw_hold_cycles: got %0d want 3", hn); end
    tests_run++; if (pl !== 3'b100) begin tests_failed++; $display("FAIL lw_pulse: got %b want 100", pl); end
    tests_run++; if (rl !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_data: got %h want deadbeef", rl); end
    tests_run++; if (ex !== 1'b0) begin tests_failed++; $display("FAIL lw_spurious: got %b want 0", ex); end
  endtask

  task automatic test_lb_lbu();
    drive_txn(1'b1, 3'b000, 32'h1003, 32'h0, 32'h80112233, 1'b0, 1, 0, 0,
              hn, rn, ra, rw, rb, rwe, st, rk, pl, rl, ex);
    tests_run++; if (rb !== 4'b1000) begin tests_failed++; $display("FAIL lb_be: got %b want 1000", rb); end
    tests_run++; if (ra !== 32'h1000) begin tests_failed++; $display("FAIL lb_addr: got %h want 00001000", ra); end
    tests_run++; if (rl !== 32'hFFFFFF80 || pl !== 3'b100) begin
      tests_failed++; $display("FAIL lb_data: got %h/%b want ffffff80/100", rl, pl); end
    drive_txn(1'b1, 3'b100, 32'h1003, 32'h0, 32'h80112233, 1'b0, 1, 0, 0,
              hn, rn, ra, rw, rb, rwe, st, rk, pl, rl, ex);
    tests_run++; if (rl !== 32'h00000080 || pl !== 3'b100) begin
      tests_failed++; $display("FAIL lbu_data: got %h/%b want 00000080/100", rl, pl); end
  endtask

  task automatic test_sh_delay();
    drive_txn(1'b0, 3'b001, 32'h2002, 32'h0000ABCD, 32'h0, 1'b0, 3, 0, 0,
              hn, rn, ra, rw, rb, rwe, st, rk, pl, rl, ex);
    tests_run++; if (rn != 3) begin tests_failed++; $display("FAIL sh_req_cycles: got %0d want 3", rn); end
    tests_run++; if (st !== 1'b1) begin tests_failed++; $display("FAIL sh_stable: got %b want 1", st); end
    tests_run++; if (ra !== 32'h2000) begin tests_failed++; $display("FAIL sh_addr: got %h want 00002000", ra); end
    tests_run++; if (rb !== 4'b1100) begin tests_failed++; $display("FAIL sh_be: got %b want 1100", rb); end
    tests_run++; if (rw !== 32'hABCDABCD) begin tests_failed++; $display("FAIL sh_wdata: got %h want abcdabcd", rw); end
    tests_run++; if (rwe !== 1'b1) begin tests_failed++; $display("FAIL sh_we: got %b want 1", rwe); end
    tests_run++; if (pl !== 3'b100 || rl !== 32'h0) begin
      tests_failed++; $display("FAIL sh_done: got %b/%h want 100/00000000", pl, rl); end
    tests_run++; if (rk != 5) begin tests_failed++; $display("FAIL sh_latency: got %0d want 5", rk); end
  endtask

  task automatic test_misalign_illegal();
    drive_txn(1'b1, 3'b010, 32'h1002, 32'h0, 32'h0, 1'b0, 1, 0, 0,
              hn, rn, ra, rw, rb, rwe, st, rk, pl, rl, ex);
    tests_run++; if (rn != 0) begin tests_failed++; $display("FAIL mis_no_req: got %0d want 0", rn); end
    tests_run++; if (rk != 1) begin tests_failed++; $display("FAIL mis_latency: got %0d want 1", rk); end
    tests_run++; if (hn != 1) begin tests_failed++; $display("FAIL mis_hold: got %0d want 1", hn); end
    tests_run++; if (pl !== 3'b010) begin tests_failed++; $display("FAIL mis_pulse: got %b want 010", pl); end
    drive_txn(1'b0, 3'b010, 32'h2001, 32'h0, 32'h0, 1'b0, 1, 0, 0,
              hn, rn, ra, rw, rb, rwe, st, rk, pl, rl, ex);
    tests_run++; if (pl !== 3'b010 || rn != 0) begin
      tests_failed++; $display("FAIL sw_mis: got %b req=%0d want 010 req=0", pl, rn); end
    drive_txn(1'b1, 3'b011, 32'h1001, 32'h0, 32'h0, 1'b0, 1, 0, 0,
              hn, rn, ra, rw, rb, rwe, st, rk, pl, rl, ex);
    tests_run++; if (pl !== 3'b001 || rn != 0) begin
      tests_failed++; $display("FAIL ld_illegal: got %b req=%0d want 001 req=0", pl, rn); end
    drive_txn(1'b0, 3'b100, 32'h1000, 32'h0, 32'h0, 1'b0, 1, 0, 0,
              hn, rn, ra, rw, rb, rwe, st, rk, pl, rl, ex);
    tests_run++; if (pl !== 3'b001 || rn != 0) begin
      tests_failed++; $display("FAIL st_illegal: got %b req=%0d want 001 req=0", pl, rn); end
  endtask

  task automatic test_flush_wait();
    drive_txn(1'b1, 3'b010, 32'h1000, 32'h0, 32'h11111111, 1'b1, 1, 1, 2,
              hn, rn, ra, rw, rb, rwe, st, rk, pl, rl, ex);
    tests_run++; if (pl !== 3'b000) begin tests_failed++; $display("FAIL flush_wait_pulse: got %b want 000", pl); end
    tests_run++; if (rk != 4) begin tests_failed++; $display("FAIL flush_wait_done: got %0d want 4", rk); end
    tests_run++; if (ex !== 1'b0) begin tests_failed++; $display("FAIL flush_wait_idle: got %b want 0", ex); end
    drive_txn(1'b1, 3'b010, 32'h1000, 32'h0, 32'h22222222, 1'b0, 2, 0, 3,
              hn, rn, ra, rw, rb, rwe, st, rk, pl, rl, ex);
    tests_run++; if (pl !== 3'b000 || rn != 2) begin
      tests_failed++; $display("FAIL flush_req_pulse: got %b req=%0d want 000 req=2", pl, rn); end
  endtask

  task automatic test_flush_accept();
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h3000; flush = 1'b1;
    #1;
    tests_run++; if (hold !== 1'b0) begin tests_failed++; $display("FAIL flush_accept_hold: got %b want 0", hold); end
    flush = 1'b0; ex_cancel = 1'b1;
    #1;
    tests_run++; if (hold !== 1'b0) begin tests_failed++; $display("FAIL cancel_hold: got %b want 0", hold); end
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_cancel = 1'b0;
    #1;
    tests_run++; if (dbus_req !== 1'b0) begin tests_failed++; $display("FAIL flush_accept_req: got %b want 0", dbus_req); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h3000; dbus_gnt = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    #1;
    tests_run++; if (dbus_req !== 1'b1) begin tests_failed++; $display("FAIL rstmid_req_before: got %b want 1", dbus_req); end
    rst = 1'b1;
    #1;
    tests_run++; if (dbus_req !== 1'b0) begin tests_failed++; $display("FAIL rstmid_req_drop: got %b want 0", dbus_req); end
    tests_run++;
    if ({dbus_we, dbus_addr, dbus_be, dbus_wdata, hold, ld_data, ld_valid, misalign_exc, access_fault} !== '0) begin
      tests_failed++; $display("FAIL rstmid_outputs: we=%b addr=%h be=%h hold=%b ld=%h want all 0",
        dbus_we, dbus_addr, dbus_be, hold, ld_data);
    end
    @(negedge clk); rst = 1'b0;
    drive_txn(1'b1, 3'b010, 32'h3004, 32'h0, 32'h12345678, 1'b0, 1, 0, 0,
              hn, rn, ra, rw, rb, rwe, st, rk, pl, rl, ex);
    tests_run++; if (pl !== 3'b100 || rl !== 32'h12345678 || rk != 3) begin
      tests_failed++; $display("FAIL rstmid_next: got %b/%h/%0d want 100/12345678/3", pl, rl, rk); end
  endtask

  task automatic test_hold_value();
    drive_txn(1'b1, 3'b001, 32'h4002, 32'h0, 32'h9ABC0000, 1'b0, 1, 0, 0,
              hn, rn, ra, rw, rb, rwe, st, rk, pl, rl, ex);
    tests_run++; if (rl !== 32'hFFFF9ABC) begin tests_failed++; $display("FAIL lh_data: got %h want ffff9abc", rl); end
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (ld_data !== 32'hFFFF9ABC) begin
      tests_failed++; $display("FAIL ld_data_hold: got %h want ffff9abc", ld_data); end
  endtask

  task automatic test_random();
    logic ld, err;
    logic [2:0] f3, ep;
    logic [31:0] a, w, rd;
    int kind, g, rv, ek, fk;
    for (int i = 0; i < 60; i++) begin
      ld = 1'($urandom); f3 = 3'($urandom); a = $urandom; w = $urandom; rd = $urandom;
      err = ($urandom_range(0, 7) == 0);
      g = $urandom_range(1, 3); rv = $urandom_range(0, 2);
      kind = m_kind(ld, f3, a);
      ek = (kind != 0) ? 1 : g + rv + 2;
      fk = ($urandom_range(0, 5) == 0) ? $urandom_range(1, ek) : 0;
      if (fk != 0)        ep = 3'b000;
      else if (kind == 1) ep = 3'b010;
      else if (kind == 2) ep = 3'b001;
      else if (err)       ep = 3'b001;
      else                ep = 3'b100;
      drive_txn(ld, f3, a, w, rd, err, g, rv, fk, hn, rn, ra, rw, rb, rwe, st, rk, pl, rl, ex);
      tests_run++;
      if (rk != ek || pl !== ep || ex !== 1'b0 || rn != ((kind != 0) ? 0 : g)) begin
        tests_failed++;
        $display("FAIL rand%0d_flow: ld=%b f3=%0d a=%h got k=%0d p=%b x=%b req=%0d want k=%0d p=%b x=0 req=%0d",
          i, ld, f3, a, rk, pl, ex, rn, ek, ep, (kind != 0) ? 0 : g);
      end
      if (kind == 0) begin
        tests_run++;
        if (ra !== {a[31:2], 2'b00} || rb !== m_be(f3, a) || rwe !== !ld || st !== 1'b1 ||
            (!ld && rw !== m_wdata(f3, w))) begin
          tests_failed++;
          $display("FAIL rand%0d_bus: got addr=%h be=%b we=%b wd=%h st=%b want addr=%h be=%b we=%b wd=%h",
            i, ra, rb, rwe, rw, st, {a[31:2], 2'b00}, m_be(f3, a), !ld, m_wdata(f3, w));
        end
      end
      if (ep == 3'b100) begin
        tests_run++;
        if (rl !== (ld ? m_load(f3, rd, a[1:0]) : 32'h0)) begin
          tests_failed++;
          $display("FAIL rand%0d_data: f3=%0d rd=%h off=%0d got %h want %h",
            i, f3, rd, a[1:0], rl, ld ? m_load(f3, rd, a[1:0]) : 32'h0);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_cancel = 1'b0;
    flush = 1'b0; ex_funct3 = '0; ex_addr = '0; ex_wdata = '0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0; dbus_err = 1'b0;
    test_reset();
    test_lw_basic();
    test_lb_lbu();
    test_sh_delay();
    test_misalign_illegal();
    test_flush_wait();
    test_flush_accept();
    test_reset_mid();
    test_hold_value();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
